// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake between the OTTER pipeline datapath and the hazard controller.
// The datapath drives through the master modport; hazard_ctrl sits on the slave modport.
interface hazard_ctrl_if;
    logic [31:0] dec_ir;
    logic        dec_valid;
    logic        br_taken;
    logic        int_req;
    logic        pc_write;
    logic        dec_en;
    logic        dec_flush;
    logic        ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        int_taken;
    logic        busy;

    modport master (
        output dec_ir, dec_valid, br_taken, int_req,
        input  pc_write, dec_en, dec_flush, ex_flush, fwd_a, fwd_b, int_taken, busy
    );

    modport slave (
        input  dec_ir, dec_valid, br_taken, int_req,
        output pc_write, dec_en, dec_flush, ex_flush, fwd_a, fwd_b, int_taken, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER pipeline: register-write scoreboard,
// operand forwarding, load-use stalls, redirect squashes and interrupt drain-then-take.
module hazard_ctrl #(
    parameter int unsigned FlushCycles = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    hazard_ctrl_if.slave hz_io
);
    localparam int unsigned CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(FlushCycles - 1);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    typedef enum logic [1:0] {StIdle, StDrain, StTake} state_e;

    sb_entry_t       ex_q, mem_q, wb_q, ex_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic       use1, use2, wr_rd, stall;
    logic       pc_write, dec_en, dec_flush, ex_flush, int_taken;
    logic       unused_bits;

    assign opcode      = hz_io.dec_ir[6:0];
    assign rd          = hz_io.dec_ir[11:7];
    assign funct3      = hz_io.dec_ir[14:12];
    assign rs1         = hz_io.dec_ir[19:15];
    assign rs2         = hz_io.dec_ir[24:20];
    assign unused_bits = ^{hz_io.dec_ir[31:25], wb_q.ld};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OpcOp:                    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OpcOpImm, OpcJalr:        begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OpcLoad:                  begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            OpcStore, OpcBranch:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OpcJal, OpcLui, OpcAuipc: writes_rd = 1'b1;
            OpcSystem: begin
                uses_rs1  = (funct3 != 3'd0) && !funct3[2];
                writes_rd = (funct3 != 3'd0);
            end
            default: ;
        endcase
    end

    // A bubble in decode uses and writes nothing; x0 is never a dependency.
    assign use1  = hz_io.dec_valid & uses_rs1 & (rs1 != 5'd0);
    assign use2  = hz_io.dec_valid & uses_rs2 & (rs2 != 5'd0);
    assign wr_rd = writes_rd & (rd != 5'd0);

    function automatic logic ld_hit(sb_entry_t e, logic [4:0] rs);
        return e.v & e.ld & (e.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(logic use_rs, logic [4:0] rs, sb_entry_t ex,
                                           sb_entry_t mem, sb_entry_t wb);
        if (!use_rs)                    return 2'd0;
        else if (ex.v && ex.rd == rs)   return 2'd1;
        else if (mem.v && mem.rd == rs) return 2'd2;
        else if (wb.v && wb.rd == rs)   return 2'd3;
        else                            return 2'd0;
    endfunction

    // Load data only exists at writeback, so a load in EX or MEM cannot be forwarded.
    assign stall = (use1 & (ld_hit(ex_q, rs1) | ld_hit(mem_q, rs1)))
                 | (use2 & (ld_hit(ex_q, rs2) | ld_hit(mem_q, rs2)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        pc_write  = 1'b1;
        dec_en    = 1'b1;
        dec_flush = 1'b0;
        ex_flush  = 1'b0;
        int_taken = 1'b0;
        case (state_q)
            StIdle: begin
                dec_flush = (cnt_q != '0);
                if (stall) begin
                    pc_write = 1'b0;
                    dec_en   = 1'b0;
                    ex_flush = 1'b1;
                end else if (hz_io.br_taken && hz_io.dec_valid) begin
                    dec_flush = 1'b1;
                    cnt_d     = CntLoad;
                end
                if (hz_io.int_req && cnt_q == '0 && !stall && !hz_io.br_taken) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                pc_write  = 1'b0;
                dec_flush = 1'b1;
                ex_flush  = 1'b1;
                if (!ex_q.v && !mem_q.v && !wb_q.v) state_d = StTake;
            end
            StTake: begin
                int_taken = 1'b1;
                dec_flush = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (hz_io.dec_valid && dec_en && !ex_flush && wr_rd) begin
            ex_d = '{v: 1'b1, rd: rd, ld: is_load};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_io.pc_write  = pc_write;
    assign hz_io.dec_en    = dec_en;
    assign hz_io.dec_flush = dec_flush;
    assign hz_io.ex_flush  = ex_flush;
    assign hz_io.int_taken = int_taken;
    assign hz_io.fwd_a     = stall ? 2'd0 : fwd_sel(use1, rs1, ex_q, mem_q, wb_q);
    assign hz_io.fwd_b     = stall ? 2'd0 : fwd_sel(use2, rs2, ex_q, mem_q, wb_q);
    assign hz_io.busy      = (state_q != StIdle) || (cnt_q != '0);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written interrupt/reset
// sequences, then random decode traffic against an in-bench pipeline model.
module tb_hazard_ctrl;
    localparam int FLUSH = 2;

    typedef struct {
        logic [31:0] ir;
        logic        v;
        logic        br;
        logic        irq;
        logic [9:0]  exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [9:0] outs;
    int n_cmp;
    int n_bad;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.FlushCycles(FLUSH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .hz_io (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outs = {hif.pc_write, hif.dec_en, hif.dec_flush, hif.ex_flush,
                   hif.fwd_a, hif.fwd_b, hif.int_taken, hif.busy};

    // Output order: pc_write, dec_en, dec_flush, ex_flush, fwd_a, fwd_b, int_taken, busy
    function automatic logic [9:0] eo(bit pcw, bit den, bit df, bit exf, int fa, int fb,
                                      bit it, bit bz);
        return {pcw, den, df, exf, 2'(fa), 2'(fb), it, bz};
    endfunction

    function automatic logic [31:0] r_add(int rd, int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] r_sub(int rd, int rs1, int rs2);
        return {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_lw(int rd, int rs1);
        return {12'b0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] b_beq(int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (pcw,den,dfl,exf,fa,fb,int,busy)",
                     name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic v, input logic br, input logic irq);
        hif.dec_ir    = ir;
        hif.dec_valid = v;
        hif.br_taken  = br;
        hif.int_req   = irq;
    endtask

    // Drive one decode cycle, check mid-cycle, then advance past the rising edge.
    task automatic apply(input string name, input logic [31:0] ir, input logic v, input logic br,
                         input logic irq, input logic [9:0] exp);
        drive(ir, v, br, irq);
        #3;
        check(name, outs, exp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: in-flight writers listed youngest first ----------
    bit         m_v[3];
    logic [4:0] m_rd[3];
    bit         m_ld[3];
    int         m_flush;   // squash cycles still owed after the current one
    int         m_ph;      // 0 normal, 1 draining, 2 taking the trap
    int         m_drain;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rd[i] = '0; m_ld[i] = 0;
        end
        m_flush = 0; m_ph = 0; m_drain = 0;
    endtask

    task automatic classify(input logic [31:0] ir, output bit u1, output bit u2,
                            output bit wr, output bit ld);
        logic [2:0] f3;
        f3 = ir[14:12];
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (ir[6:0])
            7'b0110011: begin u1 = 1; u2 = 1; wr = 1; end
            7'b0010011: begin u1 = 1; wr = 1; end
            7'b0000011: begin u1 = 1; wr = 1; ld = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; end
            7'b1100111: begin u1 = 1; wr = 1; end
            7'b1101111, 7'b0110111, 7'b0010111: wr = 1;
            7'b1110011: begin u1 = (f3 != 0) && (f3 < 4); wr = (f3 != 0); end
            default: ;
        endcase
    endtask

    function automatic int youngest_src(bit use_rs, logic [4:0] rs);
        if (!use_rs || rs == 0) return 0;
        for (int i = 0; i < 3; i++) if (m_v[i] && m_rd[i] == rs) return i + 1;
        return 0;
    endfunction

    task automatic model_step(input logic [31:0] ir, input bit v, input bit br, input bit irq,
                              output logic [9:0] exp);
        bit u1, u2, wr, ld, haz, redir, enter;
        bit pcw, den, df, exf, it, bz;
        int fa, fb, k;
        logic [4:0] rs1, rs2, rd;
        rs1 = ir[19:15]; rs2 = ir[24:20]; rd = ir[11:7];
        classify(ir, u1, u2, wr, ld);
        u1 = u1 && v && rs1 != 0;
        u2 = u2 && v && rs2 != 0;
        haz = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_v[i] && m_ld[i] && ((u1 && m_rd[i] == rs1) || (u2 && m_rd[i] == rs2))) haz = 1;
        end
        fa = haz ? 0 : youngest_src(u1, rs1);
        fb = haz ? 0 : youngest_src(u2, rs2);
        pcw = 1; den = 1; df = 0; exf = 0; it = 0; redir = 0; enter = 0;
        bz = (m_ph != 0) || (m_flush > 0);
        if (m_ph == 1) begin
            pcw = 0; df = 1; exf = 1;
        end else if (m_ph == 2) begin
            it = 1; df = 1;
        end else begin
            if (haz) begin pcw = 0; den = 0; exf = 1; end
            else if (br && v) redir = 1;
            df = redir || (m_flush > 0);
            enter = irq && m_flush == 0 && !haz && !br;
        end
        exp = eo(pcw, den, df, exf, fa, fb, it, bz);
        // advance one cycle
        for (int i = 2; i > 0; i--) begin
            m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
        end
        m_v[0] = v && den && !exf && wr && rd != 0;
        m_rd[0] = rd; m_ld[0] = ld;
        if (redir) m_flush = FLUSH - 1;
        else if (m_flush > 0) m_flush--;
        if (m_ph == 0 && enter) begin
            // drain ends one cycle after the youngest writer leaves WB
            k = 3;
            for (int i = 2; i >= 0; i--) if (m_v[i]) k = i;
            m_drain = (k == 3) ? 1 : 4 - k;
            m_ph = 1;
        end else if (m_ph == 1) begin
            m_drain--;
            if (m_drain == 0) m_ph = 2;
        end else if (m_ph == 2) begin
            m_ph = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[20];
    logic [9:0] e0, estall, edrain;

    initial begin
        logic [6:0]  ops[10];
        logic [31:0] ir;
        logic [9:0]  exp;
        logic [6:0]  op;
        bit          v, br, irq, irq_hold;

        n_cmp = 0;
        n_bad = 0;
        e0     = eo(1, 1, 0, 0, 0, 0, 0, 0);
        estall = eo(0, 0, 0, 1, 0, 0, 0, 0);
        edrain = eo(0, 1, 1, 1, 0, 0, 0, 1);

        tbl[0]  = '{32'h13,          0, 0, 0, e0};
        tbl[1]  = '{r_add(5, 1, 2),  1, 0, 0, e0};
        tbl[2]  = '{r_add(6, 5, 5),  1, 0, 0, eo(1, 1, 0, 0, 1, 1, 0, 0)};
        tbl[3]  = '{i_lw(7, 1),      1, 0, 0, e0};
        tbl[4]  = '{r_add(8, 7, 0),  1, 0, 0, estall};
        tbl[5]  = '{r_add(8, 7, 0),  1, 0, 0, estall};
        tbl[6]  = '{r_add(8, 7, 0),  1, 0, 0, eo(1, 1, 0, 0, 3, 0, 0, 0)};
        tbl[7]  = '{r_add(3, 1, 2),  1, 0, 0, e0};
        tbl[8]  = '{r_add(3, 3, 3),  1, 0, 0, eo(1, 1, 0, 0, 1, 1, 0, 0)};
        tbl[9]  = '{32'h13,          0, 0, 0, e0};
        tbl[10] = '{r_sub(9, 3, 0),  1, 0, 0, eo(1, 1, 0, 0, 2, 0, 0, 0)};
        tbl[11] = '{b_beq(1, 2),     1, 1, 0, eo(1, 1, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{32'h13,          0, 0, 0, eo(1, 1, 1, 0, 0, 0, 0, 1)};
        tbl[13] = '{32'h13,          0, 0, 0, e0};
        tbl[14] = '{i_lw(4, 1),      1, 0, 0, e0};
        tbl[15] = '{r_add(10, 4, 4), 0, 1, 0, e0};
        tbl[16] = '{r_add(10, 4, 4), 1, 1, 0, estall};
        tbl[17] = '{r_add(10, 4, 4), 1, 1, 0, eo(1, 1, 1, 0, 3, 3, 0, 0)};
        tbl[18] = '{32'h13,          0, 0, 1, eo(1, 1, 1, 0, 0, 0, 0, 1)};
        tbl[19] = '{32'h13,          0, 0, 0, e0};

        rst_n = 1'b0;
        drive(32'h13, 0, 0, 0);
        #12;
        check("reset_state", outs, e0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].ir, tbl[i].v, tbl[i].br, tbl[i].irq, tbl[i].exp);
        end

        // Interrupt with three in-flight writers, INT dropped mid-drain.
        apply("int_pre0", 32'h13, 0, 0, 0, e0);
        apply("int_pre1", 32'h13, 0, 0, 0, e0);
        apply("int_w1", r_add(11, 1, 2), 1, 0, 0, e0);
        apply("int_w2", r_add(12, 1, 2), 1, 0, 0, e0);
        apply("int_w3_entry", r_add(13, 1, 2), 1, 0, 1, e0);
        apply("int_drain1", 32'h13, 0, 0, 1, edrain);
        apply("int_drain2", 32'h13, 0, 0, 1, edrain);
        apply("int_drain3", 32'h13, 0, 0, 0, edrain);
        apply("int_drain4", 32'h13, 0, 0, 0, edrain);
        apply("int_take", 32'h13, 0, 0, 0, eo(1, 1, 1, 0, 0, 0, 1, 1));
        apply("int_idle", 32'h13, 0, 0, 0, e0);

        // Reset asserted in the middle of a drain.
        apply("rst_entry", r_add(14, 1, 2), 1, 0, 1, e0);
        drive(32'h13, 0, 0, 1);
        #3;
        check("rst_in_drain", outs, edrain);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_out", outs, e0);
        @(posedge clk);
        #2;
        drive(32'h13, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) apply($sformatf("rst_after%0d", i), 32'h13, 0, 0, 0, e0);

        // Random traffic against the model.
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1100111; ops[6] = 7'b1101111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b1110011;
        rst_n = 1'b0;
        #3;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        irq_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            ir = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  3'($urandom), 5'($urandom_range(0, 7)), op};
            v  = ($urandom_range(0, 4) != 0);
            br = ($urandom_range(0, 7) == 0);
            if (!irq_hold && $urandom_range(0, 20) == 0) irq_hold = 1;
            irq = irq_hold && !(m_ph != 0 && $urandom_range(0, 3) == 0);
            model_step(ir, v, br, irq, exp);
            if (exp[1]) irq_hold = 0;
            apply($sformatf("rand%0d", c), ir, v, br, irq, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
